// File: rtl/fp16_addsub_seq_pkg.sv
// Shared constants, field layout and FSM encoding for the sequential half-precision add/sub.
package fp16_addsub_seq_pkg;

    localparam int EXP_W     = 5;
    localparam int MANT_W    = 10;
    localparam int MANT_I    = MANT_W + 1;
    localparam int SUM_W     = MANT_W + 2;
    localparam int ALIGN_CAP = 12;

    localparam int SIGN_BIT  = EXP_W + MANT_W;
    localparam int EXP_LSB   = MANT_W;

    localparam logic [EXP_W-1:0] EXP_MAX     = '1;
    localparam logic [EXP_W-1:0] EXP_ONE     = EXP_W'(1);
    localparam logic [EXP_W-1:0] ALIGN_CAP_E = EXP_W'(ALIGN_CAP);
    localparam logic [15:0]      FP_ZERO     = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_UNPACK = 3'd1,
        ST_ORDER  = 3'd2,
        ST_ALIGN  = 3'd3,
        ST_ADDSUB = 3'd4,
        ST_NORM   = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    function automatic logic [15:0] fp_inf(input logic s);
        return {s, EXP_MAX, {MANT_W{1'b0}}};
    endfunction

endpackage

// File: rtl/fp16_addsub_seq_mant_cmp11.sv
// 11-bit mantissa comparator: ripple-carry x + ~y + 1, reports ge=1 when x-y is non-negative.
module fp16_addsub_seq_mant_cmp11
    import fp16_addsub_seq_pkg::*;
(
    input  logic [MANT_I-1:0] x,
    input  logic [MANT_I-1:0] y,
    output logic              ge
);

    logic [MANT_I:0] carry;
    logic            sign_bit;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < MANT_I; i++) begin : g_ripple
        assign carry[i+1] = (x[i] & ~y[i]) | (carry[i] & (x[i] ^ ~y[i]));
    end

    // Zero-extended operands: the extra top bit is 0 + 1 + carry-in.
    assign sign_bit = ~carry[MANT_I];
    assign ge       = ~sign_bit;

endmodule

// File: rtl/fp16_addsub_seq.sv
// Multi-cycle IEEE half add/subtract: one op in flight, valid/ready on both sides.
//   state  | meaning
//   IDLE   | waiting for operands, in_ready high
//   UNPACK | split fields, flush zero-exponent operands, catch inf/NaN operands
//   ORDER  | pick larger magnitude, result sign, exponent difference
//   ALIGN  | shift smaller mantissa right one bit per cycle (or zero it past the cap)
//   ADDSUB | 12-bit mantissa add or subtract
//   NORM   | normalise one bit per cycle, detect overflow/underflow, pack result
//   DONE   | result held with out_valid until out_ready
module fp16_addsub_seq
    import fp16_addsub_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        busy
);

    state_t state, state_nxt;

    logic [15:0]       a_r, b_r;
    logic              sub_r;
    logic              sign_a, sign_b, eff_sub, res_sign;
    logic [EXP_W-1:0]  exp_a, exp_b, exp_w, diff;
    logic [MANT_I-1:0] mant_a, mant_b, mant_l, mant_s;
    logic [SUM_W-1:0]  sum;

    logic              cmp_ge, is_special, a_is_l, norm_exit;
    logic [EXP_W-1:0]  diff_ord;

    fp16_addsub_seq_mant_cmp11 u_mant_cmp11 (
        .x  (mant_a),
        .y  (mant_b),
        .ge (cmp_ge)
    );

    always_comb begin
        is_special = (a_r[EXP_LSB +: EXP_W] == EXP_MAX) || (b_r[EXP_LSB +: EXP_W] == EXP_MAX);
        a_is_l     = (exp_a > exp_b) || ((exp_a == exp_b) && cmp_ge);
        diff_ord   = a_is_l ? (exp_a - exp_b) : (exp_b - exp_a);
        norm_exit  = sum[SUM_W-1] || (sum == '0) || sum[MANT_W] || (exp_w == EXP_ONE);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (in_valid) state_nxt = ST_UNPACK;
            ST_UNPACK: state_nxt = is_special ? ST_DONE : ST_ORDER;
            ST_ORDER:  state_nxt = (diff_ord != '0) ? ST_ALIGN : ST_ADDSUB;
            ST_ALIGN:  if ((diff >= ALIGN_CAP_E) || (diff == EXP_ONE)) state_nxt = ST_ADDSUB;
            ST_ADDSUB: state_nxt = ST_NORM;
            ST_NORM:   if (norm_exit) state_nxt = ST_DONE;
            ST_DONE:   if (out_ready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_IDLE);
        busy      = (state != ST_IDLE);
        out_valid = (state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_r      <= '0;
            b_r      <= '0;
            sub_r    <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            eff_sub  <= 1'b0;
            res_sign <= 1'b0;
            exp_a    <= '0;
            exp_b    <= '0;
            exp_w    <= '0;
            diff     <= '0;
            mant_a   <= '0;
            mant_b   <= '0;
            mant_l   <= '0;
            mant_s   <= '0;
            sum      <= '0;
            result   <= FP_ZERO;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b;
                        sub_r <= sub;
                    end
                end
                ST_UNPACK: begin
                    sign_a  <= a_r[SIGN_BIT];
                    sign_b  <= b_r[SIGN_BIT] ^ sub_r;
                    eff_sub <= a_r[SIGN_BIT] ^ b_r[SIGN_BIT] ^ sub_r;
                    exp_a   <= a_r[EXP_LSB +: EXP_W];
                    exp_b   <= b_r[EXP_LSB +: EXP_W];
                    mant_a  <= (a_r[EXP_LSB +: EXP_W] == '0) ? '0 : {1'b1, a_r[MANT_W-1:0]};
                    mant_b  <= (b_r[EXP_LSB +: EXP_W] == '0) ? '0 : {1'b1, b_r[MANT_W-1:0]};
                    if (is_special) begin
                        result <= (a_r[EXP_LSB +: EXP_W] == EXP_MAX) ? a_r
                                  : {b_r[SIGN_BIT] ^ sub_r, b_r[SIGN_BIT-1:0]};
                    end
                end
                ST_ORDER: begin
                    res_sign <= a_is_l ? sign_a : sign_b;
                    exp_w    <= a_is_l ? exp_a  : exp_b;
                    mant_l   <= a_is_l ? mant_a : mant_b;
                    mant_s   <= a_is_l ? mant_b : mant_a;
                    diff     <= diff_ord;
                end
                ST_ALIGN: begin
                    if (diff >= ALIGN_CAP_E) begin
                        mant_s <= '0;
                        diff   <= '0;
                    end else begin
                        mant_s <= mant_s >> 1;
                        diff   <= diff - 1'b1;
                    end
                end
                ST_ADDSUB: begin
                    sum <= eff_sub ? ({1'b0, mant_l} - {1'b0, mant_s})
                                   : ({1'b0, mant_l} + {1'b0, mant_s});
                end
                ST_NORM: begin
                    // Packing happens on the exit cycle so DONE only has to hold the value.
                    if (sum[SUM_W-1]) begin
                        if (exp_w == EXP_MAX - 1'b1) result <= fp_inf(res_sign);
                        else result <= {res_sign, exp_w + 1'b1, sum[MANT_W:1]};
                    end else if ((sum == '0) || (!sum[MANT_W] && (exp_w == EXP_ONE))) begin
                        result <= FP_ZERO;
                    end else if (sum[MANT_W]) begin
                        result <= {res_sign, exp_w, sum[MANT_W-1:0]};
                    end else begin
                        sum   <= sum << 1;
                        exp_w <= exp_w - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_addsub_seq.sv
// Directed and random checks of fp16_addsub_seq against an integer-arithmetic reference model.
module tb_fp16_addsub_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fp16_addsub_seq dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Result and accept-cycle-to-first-out_valid-cycle latency (both ends inclusive).
    function automatic void ref_op(input logic [15:0] x, input logic [15:0] y, input logic s,
                                   output logic [15:0] r, output int lat);
        int     ea, eb, ma, mb, el, ml, ms, d, sm, k, align_c, norm_c;
        logic   sa, sb, sl, eff;
        longint mga, mgb;
        ea = int'(x[14:10]);
        eb = int'(y[14:10]);
        sa = x[15];
        sb = y[15] ^ s;
        if (ea == 31 || eb == 31) begin
            r   = (ea == 31) ? x : {sb, y[14:0]};
            lat = 3;
            return;
        end
        ma  = (ea == 0) ? 0 : 1024 + int'(x[9:0]);
        mb  = (eb == 0) ? 0 : 1024 + int'(y[9:0]);
        mga = longint'(ma) << ea;
        mgb = longint'(mb) << eb;
        eff = x[15] ^ y[15] ^ s;
        if (mga >= mgb) begin
            el = ea; ml = ma; ms = mb; sl = sa; d = ea - eb;
        end else begin
            el = eb; ml = mb; ms = ma; sl = sb; d = eb - ea;
        end
        align_c = (d == 0) ? 0 : ((d >= 12) ? 1 : d);
        ms      = (d >= 12) ? 0 : (ms >> d);
        sm      = eff ? (ml - ms) : (ml + ms);
        if (sm == 0) begin
            r = 16'h0000; norm_c = 1;
        end else if (sm >= 2048) begin
            norm_c = 1;
            if (el + 1 >= 31) r = {sl, 5'h1F, 10'h000};
            else              r = {sl, 5'(el + 1), 10'((sm >> 1) & 1023)};
        end else begin
            k = 0;
            while ((sm << k) < 1024) k++;
            if (el - k >= 1) begin
                r = {sl, 5'(el - k), 10'((sm << k) & 1023)}; norm_c = k + 1;
            end else begin
                r = 16'h0000; norm_c = el;
            end
        end
        lat = 1 + 1 + 1 + align_c + 1 + norm_c + 1;
    endfunction

    task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic s,
                          input int hold, input string tag);
        logic [15:0] er;
        int          el, lat;
        ref_op(x, y, s, er, el);
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        a = x; b = y; sub = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 2;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " out_valid"}, 32'(out_valid), 32'd1);
        check({tag, " result"}, 32'(result), 32'(er));
        check({tag, " latency"}, 32'(lat), 32'(el));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            a = ~x;
            @(posedge clk); #1;
            check({tag, " hold result"}, 32'(result), 32'(er));
            check({tag, " hold out_valid"}, 32'(out_valid), 32'd1);
            check({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " post out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " post busy"}, 32'(busy), 32'd0);
        check({tag, " post result"}, 32'(result), 32'(er));
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst result", 32'(result), 32'h0000);
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst busy", 32'(busy), 32'd0);

        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("idle out_ready no effect", 32'(out_valid), 32'd0);

        run_op(16'h3C00, 16'h3C00, 1'b0, 0, "1+1");
        check("1+1 spec value", 32'(result), 32'h4000);
        run_op(16'h3C00, 16'h3C00, 1'b1, 0, "1-1");
        run_op(16'h3C00, 16'hBC00, 1'b0, 0, "1+-1");
        run_op(16'h3C00, 16'h4000, 1'b1, 0, "1-2");
        check("1-2 spec value", 32'(result), 32'hBC00);
        run_op(16'h6400, 16'h3C00, 1'b0, 0, "1024+1");
        check("1024+1 spec value", 32'(result), 32'h6401);
        run_op(16'h7000, 16'h3C00, 1'b0, 0, "cap");
        run_op(16'h7BFF, 16'h7BFF, 1'b0, 0, "ovf");
        check("ovf spec value", 32'(result), 32'h7C00);
        run_op(16'h7C00, 16'h3C00, 1'b0, 0, "inf");
        run_op(16'h3C00, 16'h7C00, 1'b1, 0, "b inf sub");
        run_op(16'h0400, 16'h0401, 1'b1, 0, "underflow");
        run_op(16'h0000, 16'h4500, 1'b1, 0, "zero a");
        run_op(16'h4B00, 16'h3555, 1'b0, 5, "hold");

        a = 16'h6400; b = 16'h3C00; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid-align busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort result", 32'(result), 32'h0000);
        check("abort in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 40; i++) begin
            int          ea, eb;
            logic [15:0] x, y;
            ea = int'($urandom_range(0, 30));
            eb = ea + int'($urandom_range(0, 28)) - 14;
            if (eb < 0)  eb = 0;
            if (eb > 30) eb = 30;
            if (i % 10 == 3) ea = 31;
            if (i % 10 == 7) eb = 0;
            x = {1'($urandom), 5'(ea), 10'($urandom)};
            y = {1'($urandom), 5'(eb), 10'($urandom)};
            if (i % 5 == 1) y[9:0] = x[9:0];
            run_op(x, y, 1'($urandom), int'($urandom_range(0, 2)), $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
